// File: rtl/adc_input_pkg.sv
// adc_input_pkg: shared state encoding and parameter defaults for the ADC capture path.
package adc_input_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] TEST_INIT_DEF = 16'h0000;
endpackage

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: captures a fixed-length packet of ADC samples (or a test ramp)
// into a single-register AXI-Stream master with sticky overflow/complete status.
module adc_capture_ctrl
    import adc_input_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] TEST_INIT = DATA_W'(TEST_INIT_DEF)
) (
    input  logic                m00_axis_aclk,
    input  logic                m00_axis_aresetn,
    input  logic [DATA_W-1:0]   smp_data,
    input  logic                smp_valid,
    input  logic [31:0]         cfg_dsize,
    input  logic                cfg_test,
    input  logic                cfg_start,
    output logic                sr_pc,
    output logic                sr_ovf,
    output logic                sr_busy,
    output logic                m00_axis_tvalid,
    output logic [DATA_W-1:0]   m00_axis_tdata,
    output logic [DATA_W/8-1:0] m00_axis_tstrb,
    output logic                m00_axis_tlast,
    input  logic                m00_axis_tready
);
    state_t            state_q, state_d;
    logic [31:0]       len_q, len_d, cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d, tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic              pc_q, pc_d, ovf_q, ovf_d;
    logic              hs, last_smp;

    assign hs       = tvalid_q & m00_axis_tready;
    // cnt_q never exceeds len_q-1, so the +1 cannot wrap even for a full 32-bit length
    assign last_smp = (cnt_q + 32'd1) == len_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        tvalid_d = tvalid_q & ~hs;
        tlast_d  = tlast_q & ~hs;
        tdata_d  = tdata_q;
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (cfg_start && cfg_dsize != 32'd0) begin
                state_d = RUN;
                len_d   = cfg_dsize;
                mode_d  = cfg_test;
                cnt_d   = 32'd0;
                tcnt_d  = TEST_INIT;
                pc_d    = 1'b0;
                ovf_d   = 1'b0;
            end
            RUN: if (smp_valid) begin
                if (!tvalid_q || hs) begin
                    tvalid_d = 1'b1;
                    tdata_d  = mode_q ? tcnt_q : smp_data;
                    tlast_d  = last_smp;
                    cnt_d    = cnt_q + 32'd1;
                    tcnt_d   = tcnt_q + DATA_W'(1);
                    state_d  = last_smp ? DRAIN : RUN;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            DRAIN: if (hs) begin
                state_d = IDLE;
                pc_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q  <= IDLE;
            len_q    <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            pc_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            pc_q     <= pc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sr_pc           = pc_q;
    assign sr_ovf          = ovf_q;
    assign sr_busy         = state_q != IDLE;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = '1;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scoreboard bench; two instances share stimulus,
// one with the default test start value and one starting the ramp at FFFE.
module tb_adc_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] smp_data = '0;
    logic        smp_valid = 1'b0;
    logic [31:0] cfg_dsize = '0;
    logic        cfg_test = 1'b0;
    logic        cfg_start = 1'b0;
    logic        tready = 1'b1;
    logic        pc0, ovf0, busy0, tv0, tl0, pc1, ovf1, busy1, tv1, tl1;
    logic [15:0] td0, td1;
    logic [1:0]  ts0, ts1;
    int          errors = 0;
    int          checks = 0;

    typedef struct {logic test; logic [15:0] val; logic last;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    adc_capture_ctrl dut0 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .smp_data(smp_data), .smp_valid(smp_valid),
        .cfg_dsize(cfg_dsize), .cfg_test(cfg_test), .cfg_start(cfg_start),
        .sr_pc(pc0), .sr_ovf(ovf0), .sr_busy(busy0), .m00_axis_tvalid(tv0), .m00_axis_tdata(td0),
        .m00_axis_tstrb(ts0), .m00_axis_tlast(tl0), .m00_axis_tready(tready)
    );

    adc_capture_ctrl #(.TEST_INIT(16'hFFFE)) dut1 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .smp_data(smp_data), .smp_valid(smp_valid),
        .cfg_dsize(cfg_dsize), .cfg_test(cfg_test), .cfg_start(cfg_start),
        .sr_pc(pc1), .sr_ovf(ovf1), .sr_busy(busy1), .m00_axis_tvalid(tv1), .m00_axis_tdata(td1),
        .m00_axis_tstrb(ts1), .m00_axis_tlast(tl1), .m00_axis_tready(tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic [15:0] v, input logic l);
        exp_t e;
        e.test = t;
        e.val  = v;
        e.last = l;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic start(input logic [31:0] ds, input logic t);
        cfg_dsize = ds;
        cfg_test  = t;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic wait_last();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = tv0 && tready && tl0;
        end
        if (!seen) chk("last_timeout", 0, 1);
        step();
    endtask

    // Scoreboard: every handshake pops the oldest expected beat of that instance
    always @(negedge clk) begin
        if (rst_n && tv0 && tready) begin
            exp_t e;
            if (q0.size() == 0) chk("extra_beat0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("tdata0", td0, e.test ? 16'(16'h0000 + e.val) : e.val);
                chk("tlast0", tl0, e.last);
                chk("tstrb0", ts0, 2'b11);
            end
        end
        if (rst_n && tv1 && tready) begin
            exp_t e;
            if (q1.size() == 0) chk("extra_beat1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("tdata1", td1, e.test ? 16'(16'hFFFE + e.val) : e.val);
                chk("tlast1", tl1, e.last);
                chk("tstrb1", ts1, 2'b11);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tvalid", tv0, 0);
        chk("rst_tlast", tl0, 0);
        chk("rst_tdata", td0, 0);
        chk("rst_pc", pc0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_busy", busy0, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_tvalid", tv0, 0);
        // test ramp, 4 beats, constant smp_valid
        start(4, 1);
        chk("t1_busy", busy0, 1);
        smp_valid = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 16'(i), i == 3);
        wait_last();
        chk("t1_pc0", pc0, 1);
        chk("t1_pc1", pc1, 1);
        chk("t1_ovf", ovf0, 0);
        chk("t1_busy_done", busy0, 0);
        smp_valid = 1'b0;
        step();
        // back-pressure with sample overflow
        tready = 1'b0;
        start(3, 0);
        smp_valid = 1'b1;
        smp_data = 16'h00A1;
        push(1'b0, 16'h00A1, 1'b0);
        step();
        smp_data = 16'h00A2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", tv0, 1);
            chk("t2_hold_data", td0, 16'h00A1);
            chk("t2_hold_last", tl0, 0);
        end
        chk("t2_ovf_mid", ovf0, 1);
        tready = 1'b1;
        push(1'b0, 16'h00A2, 1'b0);
        step();
        smp_data = 16'h00A3;
        push(1'b0, 16'h00A3, 1'b1);
        step();
        smp_valid = 1'b0;
        wait_last();
        chk("t2_pc", pc0, 1);
        chk("t2_ovf", ovf0, 1);
        chk("t2_busy", busy0, 0);
        // zero-length start is ignored
        start(0, 0);
        smp_valid = 1'b1;
        repeat (3) begin
            step();
            chk("t3_busy_zero", busy0, 0);
        end
        chk("t3_pc_kept", pc0, 1);
        chk("t3_ovf_kept", ovf0, 1);
        smp_valid = 1'b0;
        // single-beat packet
        start(1, 0);
        smp_data = 16'h55AA;
        smp_valid = 1'b1;
        push(1'b0, 16'h55AA, 1'b1);
        wait_last();
        smp_valid = 1'b0;
        chk("t3_pc", pc0, 1);
        chk("t3_ovf_cleared", ovf0, 0);
        // mid-packet restart with new length/mode has no effect
        start(4, 1);
        for (int i = 0; i < 4; i++) push(1'b1, 16'(i), i == 3);
        smp_valid = 1'b1;
        smp_data = 16'h1234;
        step();
        cfg_dsize = 8;
        cfg_test = 1'b0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_last();
        chk("t4_pc", pc0, 1);
        chk("t4_busy", busy0, 0);
        repeat (3) step();
        smp_valid = 1'b0;
        chk("t4_q_empty", q0.size(), 0);
        // reset in the middle of an 8-beat packet
        start(8, 1);
        for (int i = 0; i < 8; i++) push(1'b1, 16'(i), i == 7);
        smp_valid = 1'b1;
        begin
            int h = 0;
            for (int i = 0; i < 30 && h < 2; i++) begin
                @(negedge clk);
                if (tv0 && tready) h++;
            end
            if (h < 2) chk("t5_hs_timeout", h, 2);
        end
        step();
        rst_n = 1'b0;
        smp_valid = 1'b0;
        #1;
        chk("t5_rst_tvalid0", tv0, 0);
        chk("t5_rst_tvalid1", tv1, 0);
        chk("t5_rst_tlast", tl0, 0);
        chk("t5_rst_tdata", td0, 0);
        chk("t5_rst_pc", pc0, 0);
        chk("t5_rst_ovf", ovf0, 0);
        chk("t5_rst_busy", busy0, 0);
        q0.delete();
        q1.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t5_post_rst_tvalid", tv0, 0);
        start(8, 1);
        for (int i = 0; i < 8; i++) push(1'b1, 16'(i), i == 7);
        smp_valid = 1'b1;
        wait_last();
        smp_valid = 1'b0;
        chk("t5_pc", pc0, 1);
        chk("t5_busy", busy0, 0);
        repeat (2) step();
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
